button_conditioner: RTL and testbench

- Parametrised successor to the single-purpose debouncer for the FPGA button/switch input path. Sits after the synchronizer.
- For each of WIDTH channels, produces a debounced level, with debouncing applied symmetrically to both press and release.
- Also produces one-cycle press/release event pulses and an optional hold-to-repeat press stream.
- Replaces the separate debouncer and edge-detector pair in front of user logic.

---
 rtl/button_conditioner_pkg.sv | 18 +
 rtl/button_conditioner_sample_tick_gen.sv | 37 +++
 rtl/button_conditioner.sv | 130 +++++++++++++
 tb/tb_button_conditioner.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and width helpers for the button conditioner.
package button_conditioner_pkg;

    // Kind of output pulse a channel wants to emit in the current cycle.
    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_RELEASE = 2'd2
    } pulse_ev_e;

    // Bits needed to hold 0..maxCount-1, never narrower than one bit.
    function automatic int cnt_width(input int maxCount);
        int w;
        w = $clog2(maxCount);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_conditioner_sample_tick_gen.sv
// Shared sample-tick generator: one-cycle tick every SAMPLE_COUNT_MAX clocks.
module sample_tick_gen
    import button_conditioner_pkg::*;
#(
    parameter int SAMPLE_COUNT_MAX = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = cnt_width(SAMPLE_COUNT_MAX);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_COUNT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap the counter back to zero after the last count of the period.
    always_comb begin
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
            count_d = '0;
        end
    end

    // Counter register; restarts from zero on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: debounced level, press/release pulses
// and optional hold-to-repeat press pulses, all paced by one shared tick.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int WIDTH            = 4,
    parameter int SAMPLE_COUNT_MAX = 25000,
    parameter int PULSE_COUNT_MAX  = 150,
    parameter int REPEAT_EN        = 1,
    parameter int REPEAT_DELAY     = 500,
    parameter int REPEAT_PERIOD    = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sync_in_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o
);

    localparam int            DW     = cnt_width(PULSE_COUNT_MAX);
    localparam logic [DW-1:0] D_LAST = DW'(PULSE_COUNT_MAX - 1);

    logic tick;

    sample_tick_gen #(
        .SAMPLE_COUNT_MAX(SAMPLE_COUNT_MAX)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [DW-1:0] disagree_q;
        logic [DW-1:0] disagree_d;
        logic          level_q;
        logic          level_d;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;
        logic          repeatHit;
        pulse_ev_e     pulseEv;

        // Count consecutive disagreeing samples, flip the level on the last
        // one and pick the pulse to emit; a release beats a repeat press.
        always_comb begin
            disagree_d = disagree_q;
            level_d    = level_q;
            pulseEv    = EV_NONE;
            if (tick) begin
                if (sync_in_i[i] == level_q) begin
                    disagree_d = '0;
                end else if (disagree_q == D_LAST) begin
                    level_d    = ~level_q;
                    disagree_d = '0;
                    pulseEv    = level_q ? EV_RELEASE : EV_PRESS;
                end else begin
                    disagree_d = disagree_q + DW'(1);
                end
            end
            if ((pulseEv == EV_NONE) && repeatHit) begin
                pulseEv = EV_PRESS;
            end
            press_d   = (pulseEv == EV_PRESS);
            release_d = (pulseEv == EV_RELEASE);
        end

        // Channel state and registered pulses; reset discards partial counts.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                disagree_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
            end else begin
                disagree_q <= disagree_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
            end
        end

        if (REPEAT_EN != 0) begin : g_rep
            localparam int            HW     = cnt_width(REPEAT_DELAY);
            localparam logic [HW-1:0] H_LAST = HW'(REPEAT_DELAY - 1);
            localparam logic [HW-1:0] H_RELD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

            logic [HW-1:0] hold_q;
            logic [HW-1:0] hold_d;
            logic          hit;

            // Hold counter: idle at zero while low (so it is zero at the rise),
            // then counts ticks and reloads so later repeats come every period.
            always_comb begin
                hold_d = hold_q;
                hit    = 1'b0;
                if (!level_q) begin
                    hold_d = '0;
                end else if (tick) begin
                    if (hold_q == H_LAST) begin
                        hit    = 1'b1;
                        hold_d = H_RELD;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end

            // Hold counter register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign repeatHit = hit;
        end else begin : g_norep
            assign repeatHit = 1'b0;
        end

        assign level_o[i]   = level_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: one DUT with auto-repeat and
// one without, driven identically and compared to a behavioural model.
module tb_button_conditioner;

    localparam int W   = 2;
    localparam int SCM = 4;
    localparam int PCM = 3;
    localparam int RD  = 5;
    localparam int RP  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] syncIn;
    logic [W-1:0] levelA, pressA, releaseA;
    logic [W-1:0] levelB, pressB, releaseB;

    int compared   = 0;
    int mismatched = 0;
    int cycleIdx   = 0;

    // Model state
    int           mCyc;
    int           mRun  [W];
    int           mHeld [W];
    logic [W-1:0] mLevel;
    logic [W-1:0] mPressA;
    logic [W-1:0] mPressB;
    logic [W-1:0] mRel;

    always #5 clk = ~clk;

    button_conditioner #(
        .WIDTH(W), .SAMPLE_COUNT_MAX(SCM), .PULSE_COUNT_MAX(PCM),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dutRep (
        .clk(clk), .rst_n(rst_n), .sync_in_i(syncIn),
        .level_o(levelA), .press_o(pressA), .release_o(releaseA)
    );

    button_conditioner #(
        .WIDTH(W), .SAMPLE_COUNT_MAX(SCM), .PULSE_COUNT_MAX(PCM),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dutNoRep (
        .clk(clk), .rst_n(rst_n), .sync_in_i(syncIn),
        .level_o(levelB), .press_o(pressB), .release_o(releaseB)
    );

    // Behavioural model: tick is every SCM-th cycle since reset; a level
    // flips after PCM consecutive disagreeing ticks; repeats fire when the
    // number of ticks held high reaches RD, RD+RP, RD+2RP, ...
    function automatic void modelEdge(input logic [W-1:0] inVal, input logic rstVal);
        bit isTick;
        bit wasHigh;
        bit fell;
        mPressA = '0;
        mPressB = '0;
        mRel    = '0;
        if (!rstVal) begin
            mCyc   = 0;
            mLevel = '0;
            for (int ch = 0; ch < W; ch++) begin
                mRun[ch]  = 0;
                mHeld[ch] = 0;
            end
            return;
        end
        isTick = ((mCyc % SCM) == SCM - 1);
        for (int ch = 0; ch < W; ch++) begin
            wasHigh = mLevel[ch];
            fell    = 1'b0;
            if (isTick) begin
                if (inVal[ch] == mLevel[ch]) begin
                    mRun[ch] = 0;
                end else begin
                    mRun[ch] = mRun[ch] + 1;
                    if (mRun[ch] == PCM) begin
                        mRun[ch]   = 0;
                        mLevel[ch] = ~mLevel[ch];
                        if (mLevel[ch]) begin
                            mPressA[ch] = 1'b1;
                            mPressB[ch] = 1'b1;
                        end else begin
                            mRel[ch] = 1'b1;
                            fell     = 1'b1;
                        end
                    end
                end
            end
            if (!wasHigh) begin
                mHeld[ch] = 0;
            end else if (isTick) begin
                mHeld[ch] = mHeld[ch] + 1;
                if (!fell && mHeld[ch] >= RD && ((mHeld[ch] - RD) % RP) == 0) begin
                    mPressA[ch] = 1'b1;
                end
            end
        end
        mCyc = mCyc + 1;
    endfunction

    // Drive one cycle of inputs, advance model at the edge, settle past it.
    task automatic stepCycle(input logic [W-1:0] inVal, input logic rstVal);
        syncIn = inVal;
        rst_n  = rstVal;
        @(posedge clk);
        modelEdge(inVal, rstVal);
        #1;
        if (rstVal) cycleIdx++;
        else        cycleIdx = 0;
    endtask

    task automatic doReset(input int n);
        for (int k = 0; k < n; k++) begin
            stepCycle(W'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        v = 2'b11;
        for (int k = 0; k < 10; k++) begin
            stepCycle(v, 1'b0);
            v = ~v;
            compared++;
            if ({levelA, pressA, releaseA, levelB, pressB, releaseB} !== 12'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_outputs k=%0d got=%b exp=0", k,
                         {levelA, pressA, releaseA, levelB, pressB, releaseB});
            end
        end
    endtask

    task automatic test_clean_press();
        int firstRise, pressCnt, pressAt;
        bit ch1Seen;
        firstRise = -1; pressCnt = 0; pressAt = -1; ch1Seen = 0;
        doReset(2);
        for (int k = 0; k < 20; k++) begin
            stepCycle(2'b01, 1'b1);
            compared++;
            if ({levelA, pressA, releaseA} !== {mLevel, mPressA, mRel}) begin
                mismatched++;
                $display("[TB] FAIL clean_press_rep cyc=%0d got=%b exp=%b", cycleIdx,
                         {levelA, pressA, releaseA}, {mLevel, mPressA, mRel});
            end
            if (levelA[0] && firstRise < 0) firstRise = cycleIdx;
            if (pressA[0]) begin pressCnt++; pressAt = cycleIdx; end
            if (levelA[1] | pressA[1] | releaseA[1]) ch1Seen = 1;
        end
        compared++;
        if (firstRise !== 12) begin
            mismatched++;
            $display("[TB] FAIL clean_press_rise got=%0d exp=12", firstRise);
        end
        compared++;
        if (pressCnt !== 1 || pressAt !== 12) begin
            mismatched++;
            $display("[TB] FAIL clean_press_pulse got=%0d@%0d exp=1@12", pressCnt, pressAt);
        end
        compared++;
        if (ch1Seen !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clean_press_ch1 got=%0d exp=0", ch1Seen);
        end
    endtask

    task automatic test_glitch();
        int firstRise;
        logic [W-1:0] v;
        firstRise = -1;
        doReset(2);
        for (int c = 0; c < 30; c++) begin
            v = (c >= 8 && c < 12) ? 2'b00 : 2'b01;
            stepCycle(v, 1'b1);
            compared++;
            if ({levelA, pressA, releaseA} !== {mLevel, mPressA, mRel}) begin
                mismatched++;
                $display("[TB] FAIL glitch_rep cyc=%0d got=%b exp=%b", cycleIdx,
                         {levelA, pressA, releaseA}, {mLevel, mPressA, mRel});
            end
            if (levelA[0] && firstRise < 0) firstRise = cycleIdx;
        end
        compared++;
        if (firstRise !== 24) begin
            mismatched++;
            $display("[TB] FAIL glitch_rise got=%0d exp=24", firstRise);
        end
    endtask

    task automatic test_release();
        int relCnt, relAt, lateCnt;
        logic [W-1:0] v;
        relCnt = 0; relAt = -1; lateCnt = 0;
        doReset(2);
        for (int c = 0; c < 32; c++) begin
            v = (c < 12) ? 2'b01 : 2'b00;
            stepCycle(v, 1'b1);
            compared++;
            if ({levelB, pressB, releaseB} !== {mLevel, mPressB, mRel}) begin
                mismatched++;
                $display("[TB] FAIL release_norep cyc=%0d got=%b exp=%b", cycleIdx,
                         {levelB, pressB, releaseB}, {mLevel, mPressB, mRel});
            end
            if (releaseA[0]) begin relCnt++; relAt = cycleIdx; end
            if (cycleIdx > 12 && pressA[0]) lateCnt++;
            if (pressA[0] && releaseA[0]) lateCnt++;
        end
        compared++;
        if (relCnt !== 1 || relAt !== 24) begin
            mismatched++;
            $display("[TB] FAIL release_pulse got=%0d@%0d exp=1@24", relCnt, relAt);
        end
        compared++;
        if (lateCnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL release_no_press got=%0d exp=0", lateCnt);
        end
        compared++;
        if (levelA !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL release_level got=%b exp=00", levelA);
        end
    endtask

    task automatic test_auto_repeat();
        int qa[$];
        int qb[$];
        int expA[5];
        expA = '{12, 32, 40, 48, 56};
        doReset(2);
        for (int c = 0; c < 60; c++) begin
            stepCycle(2'b01, 1'b1);
            compared++;
            if ({levelA, pressA, releaseA} !== {mLevel, mPressA, mRel}) begin
                mismatched++;
                $display("[TB] FAIL repeat_rep cyc=%0d got=%b exp=%b", cycleIdx,
                         {levelA, pressA, releaseA}, {mLevel, mPressA, mRel});
            end
            if (pressA[0]) qa.push_back(cycleIdx);
            if (pressB[0]) qb.push_back(cycleIdx);
        end
        compared++;
        if (qa.size() !== 5) begin
            mismatched++;
            $display("[TB] FAIL repeat_count got=%0d exp=5", qa.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                compared++;
                if (qa[k] !== expA[k]) begin
                    mismatched++;
                    $display("[TB] FAIL repeat_time idx=%0d got=%0d exp=%0d", k, qa[k], expA[k]);
                end
            end
        end
        compared++;
        if (qb.size() !== 1 || qb[0] !== 12) begin
            mismatched++;
            $display("[TB] FAIL norep_press got_count=%0d exp=1@12", qb.size());
        end
    endtask

    task automatic test_mid_reset();
        int firstRise;
        firstRise = -1;
        doReset(2);
        for (int c = 0; c < 9; c++) stepCycle(2'b01, 1'b1);
        stepCycle(2'b01, 1'b0);
        compared++;
        if ({levelA, pressA, releaseA, levelB, pressB, releaseB} !== 12'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_clear got=%b exp=0",
                     {levelA, pressA, releaseA, levelB, pressB, releaseB});
        end
        for (int c = 0; c < 16; c++) begin
            stepCycle(2'b01, 1'b1);
            compared++;
            if ({levelA, pressA, releaseA} !== {mLevel, mPressA, mRel}) begin
                mismatched++;
                $display("[TB] FAIL mid_reset_rep cyc=%0d got=%b exp=%b", cycleIdx,
                         {levelA, pressA, releaseA}, {mLevel, mPressA, mRel});
            end
            if (levelA[0] && firstRise < 0) firstRise = cycleIdx;
        end
        compared++;
        if (firstRise !== 12) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_rise got=%0d exp=12", firstRise);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        int           remain [W];
        logic         r;
        v = '0;
        for (int ch = 0; ch < W; ch++) remain[ch] = $urandom_range(1, 60);
        doReset(2);
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < W; ch++) begin
                remain[ch]--;
                if (remain[ch] <= 0) begin
                    v[ch]      = ~v[ch];
                    remain[ch] = $urandom_range(1, 60);
                end
            end
            r = ($urandom_range(0, 399) != 0);
            stepCycle(v, r);
            compared++;
            if ({levelA, pressA, releaseA} !== {mLevel, mPressA, mRel}) begin
                mismatched++;
                $display("[TB] FAIL random_rep step=%0d got=%b exp=%b", c,
                         {levelA, pressA, releaseA}, {mLevel, mPressA, mRel});
            end
            compared++;
            if ({levelB, pressB, releaseB} !== {mLevel, mPressB, mRel}) begin
                mismatched++;
                $display("[TB] FAIL random_norep step=%0d got=%b exp=%b", c,
                         {levelB, pressB, releaseB}, {mLevel, mPressB, mRel});
            end
        end
    endtask

    initial begin
        $display("[TB] starting button_conditioner bench");
        test_reset();
        test_clean_press();
        test_glitch();
        test_release();
        test_auto_repeat();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
